ls_control_unit: RTL and testbench
==================================

Name: ls_control_unit

Overview:
- Multi-cycle fetch/decode controller directly upstream of the load/store datapath (register file + adder + data RAM).
- Reads RV64 `ld`/`sd` instructions from an instruction memory at the current PC and decodes them into the datapath fields `a`, `b`, `w`, `din`, `load_store`.
- Pulses the datapath `enable` for exactly one cycle per instruction and advances the PC.
- Stops on a halt word or an illegal encoding.

Parameters:
- ADDR_W, 8, width of the PC / instruction-memory byte address.
- PC_START, 0, PC value loaded at reset and on each start.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins execution at PC_START; sampled only in IDLE, DONE and ERR.
- instr  input  32  instruction word at address `pc`; combinational read from instruction memory.
- pc  output  ADDR_W  instruction fetch byte address.
- dp_enable  output  1  datapath enable; high for one cycle per instruction.
- dp_load_store  output  1  1 = load (`ld`), 0 = store (`sd`).
- dp_a  output  5  store-data register (rs2); 0 for loads.
- dp_b  output  5  base-address register (rs1).
- dp_w  output  5  load destination register (rd); 0 for stores.
- dp_imm  output  64  sign-extended offset, drives datapath `din`.
- busy  output  1  high in FETCH, DECODE and EXEC.
- done  output  1  high in DONE.
- illegal  output  1  high in ERR.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; pc=PC_START; IR=0; every output = 0.
- All outputs are registered; no combinational path from `instr` or `start` to any output.
- States and transitions:
  - IDLE: start=1 -> FETCH, pc=PC_START.
  - FETCH: IR <= instr -> DECODE.
  - DECODE, IR=32'h0 (halt) -> DONE.
  - DECODE, opcode 0000011 with funct3 011 (`ld`) -> EXEC. Sets dp_load_store=1, dp_w=IR[11:7], dp_b=IR[19:15], dp_a=0, dp_imm=sext(IR[31:20]).
  - DECODE, opcode 0100011 with funct3 011 (`sd`) -> EXEC. Sets dp_load_store=0, dp_a=IR[24:20], dp_b=IR[19:15], dp_w=0, dp_imm=sext({IR[31:25],IR[11:7]}).
  - DECODE, any other word -> ERR.
  - EXEC: dp_enable=1 for this cycle only; pc <= pc+4 -> FETCH.
  - DONE: done=1. start=1 -> FETCH, pc=PC_START, done cleared.
  - ERR: illegal=1; pc holds the faulting address. start=1 -> FETCH, pc=PC_START, illegal cleared.
- Timing: 3 cycles per instruction (FETCH, DECODE, EXEC). The halt word reaches DONE 2 cycles after entering FETCH.
- dp_a, dp_b, dp_w, dp_imm and dp_load_store hold their DECODE values through EXEC and until the next successful DECODE. Halt and illegal decodes do not change them.
- PC arithmetic: modulo 2^ADDR_W. pc=2^ADDR_W-4 wraps to 0 with no flag.
- start while busy=1: ignored.
- dp_enable is never high outside EXEC. It is never high in two consecutive cycles.
- rst asserted during EXEC: dp_enable drops immediately (asynchronous), so the datapath sees no enable on the following edge.
- Sign extension: replicate the imm MSB to bit 63. Example: imm 12'hFF8 -> 64'hFFFF_FFFF_FFFF_FFF8.

Test Plan:
- Program sd x4,2(x6) = 0x00433123 at address 0, halt at 4; pulse start. Expect one dp_enable pulse with dp_load_store=0, dp_a=4, dp_b=6, dp_imm=2. Then done=1 with pc=4, 5 cycles after start.
- ld x2,3(x13) = 0x0036B103 -> dp_enable pulse with dp_load_store=1, dp_w=2, dp_b=13, dp_a=0, dp_imm=3. Next FETCH presents pc=4.
- ld x3,-8(x21) = 0xFF8AB183 -> dp_imm=64'hFFFF_FFFF_FFFF_FFF8, dp_w=3, dp_b=21.
- Word 0x00000013 at address 8 after two valid ops -> ERR with illegal=1 and pc=8. Only 2 dp_enable pulses total. A later start restarts from pc=0.
- Assert rst in the EXEC cycle of the 2nd instruction -> all outputs 0 at once, state IDLE. No further dp_enable until the next start.
- ADDR_W=4: a program of 4 `ld` ops with no halt -> pc sequence 0,4,8,12,0. start pulses while busy change nothing.

Source files
------------

// File: rtl/ls_control_unit.sv
// ls_control_unit
// ----------------------------------------------------------------------------
// Multi-cycle fetch/decode controller for the load/store datapath. It fetches
// RV64 `ld` / `sd` words from instruction memory at `pc`, decodes them into
// the datapath fields and pulses `dp_enable` once per instruction. Execution
// stops on the all-zero halt word (DONE) or on any other encoding (ERR).
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start         begin execution at PC_START (honoured in IDLE, DONE, ERR)
//   instr         instruction word at `pc` (combinational memory read)
//   pc            instruction fetch byte address
//   dp_enable     datapath enable, one cycle per executed instruction
//   dp_load_store 1 = load, 0 = store
//   dp_a          store-data register (rs2), 0 for loads
//   dp_b          base-address register (rs1)
//   dp_w          load destination register (rd), 0 for stores
//   dp_imm        sign-extended offset
//   busy          high in FETCH, DECODE and EXEC
//   done          high after a halt word
//   illegal       high after an unsupported encoding
// ----------------------------------------------------------------------------
module ls_control_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_START = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic              dp_enable,
    output logic              dp_load_store,
    output logic [4:0]        dp_a,
    output logic [4:0]        dp_b,
    output logic [4:0]        dp_w,
    output logic [63:0]       dp_imm,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_DWORD = 3'b011;

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;

    // Decode of the latched instruction word; only consulted in DECODE.
    logic is_halt;
    logic is_ld;
    logic is_sd;

    assign is_halt = (ir == 32'h0);
    assign is_ld   = (ir[6:0] == OP_LOAD)  && (ir[14:12] == F3_DWORD);
    assign is_sd   = (ir[6:0] == OP_STORE) && (ir[14:12] == F3_DWORD);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next
        // unassigned; a missing default would infer a latch.
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_next = S_FETCH;
            S_FETCH:               state_next = S_DECODE;
            S_DECODE: begin
                if (is_halt)             state_next = S_DONE;
                else if (is_ld || is_sd) state_next = S_EXEC;
                else                     state_next = S_ERR;
            end
            S_EXEC:                state_next = S_FETCH;
            default:               state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: purely from the state flops, so the reset clears
    // dp_enable asynchronously and nothing depends on instr or start.
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        dp_enable = 1'b0;
        unique case (state)
            S_FETCH, S_DECODE: busy = 1'b1;
            S_EXEC: begin
                busy      = 1'b1;
                dp_enable = 1'b1;
            end
            S_DONE:  done    = 1'b1;
            S_ERR:   illegal = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // PC, instruction register and datapath field registers.
    // The fields change only on a successful decode, so they stay stable
    // through EXEC and across halt / illegal decodes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= PC_START;
            ir            <= '0;
            dp_load_store <= 1'b0;
            dp_a          <= '0;
            dp_b          <= '0;
            dp_w          <= '0;
            dp_imm        <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: if (start) pc <= PC_START;
                S_FETCH:               ir <= instr;
                S_DECODE: begin
                    if (is_ld) begin
                        dp_load_store <= 1'b1;
                        dp_a          <= 5'd0;
                        dp_b          <= ir[19:15];
                        dp_w          <= ir[11:7];
                        dp_imm        <= {{52{ir[31]}}, ir[31:20]};
                    end else if (is_sd) begin
                        dp_load_store <= 1'b0;
                        dp_a          <= ir[24:20];
                        dp_b          <= ir[19:15];
                        dp_w          <= 5'd0;
                        dp_imm        <= {{52{ir[31]}}, ir[31:25], ir[11:7]};
                    end
                end
                // Wraps modulo 2^ADDR_W by construction.
                S_EXEC:  pc <= pc + ADDR_W'(4);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_control_unit.sv
module tb_ls_control_unit;

    // ------------------------------------------------------------------
    // Clock, reset, DUT instances (ADDR_W=8 main, ADDR_W=4 for wrap)
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic [31:0] instr, instr4;

    logic [7:0]  pc;
    logic        dp_enable, dp_load_store, busy, done, illegal;
    logic [4:0]  dp_a, dp_b, dp_w;
    logic [63:0] dp_imm;

    logic [3:0]  pc4;
    logic        dp_enable4, dp_load_store4, busy4, done4, illegal4;
    logic [4:0]  dp_a4, dp_b4, dp_w4;
    logic [63:0] dp_imm4;

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] imem4 [4];
    assign instr  = imem[pc[7:2]];
    assign instr4 = imem4[pc4[3:2]];

    ls_control_unit #(.ADDR_W(8), .PC_START(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .pc(pc),
        .dp_enable(dp_enable), .dp_load_store(dp_load_store),
        .dp_a(dp_a), .dp_b(dp_b), .dp_w(dp_w), .dp_imm(dp_imm),
        .busy(busy), .done(done), .illegal(illegal)
    );

    ls_control_unit #(.ADDR_W(4), .PC_START(4'h0)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .instr(instr4), .pc(pc4),
        .dp_enable(dp_enable4), .dp_load_store(dp_load_store4),
        .dp_a(dp_a4), .dp_b(dp_b4), .dp_w(dp_w4), .dp_imm(dp_imm4),
        .busy(busy4), .done(done4), .illegal(illegal4)
    );

    // ------------------------------------------------------------------
    // Reference model: a program is a list of operation descriptors; the
    // expected datapath fields come from the descriptor, never from bits.
    // ------------------------------------------------------------------
    typedef enum int {K_HALT, K_LD, K_SD, K_BAD} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] word;
        logic [4:0]  ra, rb, rw;
        logic [11:0] imm;
    } op_t;

    op_t prog [64];

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the held datapath fields.
    logic        m_ls;
    logic [4:0]  m_a, m_b, m_w;
    logic [63:0] m_imm;

    function automatic logic [31:0] enc_ld(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, 3'b011, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sd(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endfunction

    function automatic bit is_supported(logic [31:0] w);
        return (w == 32'h0) ||
               ((w[6:0] == 7'b0000011 || w[6:0] == 7'b0100011) && w[14:12] == 3'b011);
    endfunction

    function automatic op_t mk_ld(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
        op_t o;
        o.kind = K_LD; o.rw = rd; o.rb = rs1; o.ra = 5'd0; o.imm = imm;
        o.word = enc_ld(rd, rs1, imm);
        return o;
    endfunction

    function automatic op_t mk_sd(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
        op_t o;
        o.kind = K_SD; o.ra = rs2; o.rb = rs1; o.rw = 5'd0; o.imm = imm;
        o.word = enc_sd(rs2, rs1, imm);
        return o;
    endfunction

    function automatic op_t mk_raw(kind_t k, logic [31:0] w);
        op_t o;
        o.kind = k; o.word = w; o.ra = '0; o.rb = '0; o.rw = '0; o.imm = '0;
        return o;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = mk_raw(K_HALT, 32'h0);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) imem[i] = prog[i].word;
    endtask

    task automatic zero_model();
        m_ls = 1'b0; m_a = '0; m_b = '0; m_w = '0; m_imm = '0;
    endtask

    // ------------------------------------------------------------------
    // Scenario runner: pulses start and walks the program cycle by cycle,
    // comparing status/pc and held fields against the model. With poke
    // set, start is driven randomly while the controller is busy.
    // ------------------------------------------------------------------
    task automatic run_program(input string name, input bit poke, output int n_enables);
        logic [7:0] mpc;
        bit         fin;
        op_t        op;
        n_enables = 0;
        load_prog();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        mpc = 8'h00;
        fin = 1'b0;
        for (int k = 0; k < 80 && !fin; k++) begin
            op = prog[mpc[7:2]];
            // FETCH
            n_tests++;
            if ({busy, done, illegal, dp_enable, pc} !== {4'b1000, mpc}) begin
                n_fail++;
                $display("FAIL %s fetch[%0d]: got st=%b pc=%h, want st=1000 pc=%h",
                         name, k, {busy, done, illegal, dp_enable}, pc, mpc);
            end
            start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            // DECODE: fields still hold previous values
            n_tests++;
            if ({busy, done, illegal, dp_enable, pc, dp_load_store, dp_a, dp_b, dp_w, dp_imm} !==
                {4'b1000, mpc, m_ls, m_a, m_b, m_w, m_imm}) begin
                n_fail++;
                $display("FAIL %s decode[%0d]: got st=%b pc=%h f=%b/%0d/%0d/%0d/%h, want pc=%h f=%b/%0d/%0d/%0d/%h",
                         name, k, {busy, done, illegal, dp_enable}, pc, dp_load_store, dp_a, dp_b, dp_w, dp_imm,
                         mpc, m_ls, m_a, m_b, m_w, m_imm);
            end
            start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            case (op.kind)
                K_LD, K_SD: begin
                    m_ls  = (op.kind == K_LD);
                    m_a   = op.ra;
                    m_b   = op.rb;
                    m_w   = op.rw;
                    m_imm = {{52{op.imm[11]}}, op.imm};
                    if (dp_enable === 1'b1) n_enables++;
                    n_tests++;
                    if ({busy, done, illegal, dp_enable, pc, dp_load_store, dp_a, dp_b, dp_w, dp_imm} !==
                        {4'b1001, mpc, m_ls, m_a, m_b, m_w, m_imm}) begin
                        n_fail++;
                        $display("FAIL %s exec[%0d]: got st=%b pc=%h f=%b/%0d/%0d/%0d/%h, want st=1001 pc=%h f=%b/%0d/%0d/%0d/%h",
                                 name, k, {busy, done, illegal, dp_enable}, pc, dp_load_store, dp_a, dp_b, dp_w, dp_imm,
                                 mpc, m_ls, m_a, m_b, m_w, m_imm);
                    end
                    mpc = mpc + 8'd4;
                    start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                    @(negedge clk);
                end
                default: begin
                    fin = 1'b1;
                    start = 1'b0;
                    n_tests++;
                    if ({busy, done, illegal, dp_enable, pc, dp_load_store, dp_a, dp_b, dp_w, dp_imm} !==
                        {1'b0, op.kind == K_HALT, op.kind == K_BAD, 1'b0, mpc, m_ls, m_a, m_b, m_w, m_imm}) begin
                        n_fail++;
                        $display("FAIL %s end[%0d]: got st=%b pc=%h f=%b/%0d/%0d/%0d/%h, want halt=%0d pc=%h f=%b/%0d/%0d/%0d/%h",
                                 name, k, {busy, done, illegal, dp_enable}, pc, dp_load_store, dp_a, dp_b, dp_w, dp_imm,
                                 op.kind == K_HALT, mpc, m_ls, m_a, m_b, m_w, m_imm);
                    end
                end
            endcase
        end
        n_tests++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s budget: program did not end within 80 instructions", name);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({pc, dp_enable, dp_load_store, dp_a, dp_b, dp_w, dp_imm, busy, done, illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h en=%b st=%b%b%b, want all zero",
                     pc, dp_enable, busy, done, illegal);
        end
        rst = 1'b0;
        zero_model();
        @(negedge clk);
    endtask

    task automatic test_sd_halt();
        int ne;
        clear_prog();
        prog[0] = mk_raw(K_SD, 32'h0043_3123);
        prog[0].ra = 5'd4; prog[0].rb = 5'd6; prog[0].rw = 5'd0; prog[0].imm = 12'd2;
        run_program("sd_halt", 1'b0, ne);
        n_tests++;
        if (ne !== 1) begin
            n_fail++;
            $display("FAIL sd_halt_pulses: got %0d, want 1", ne);
        end
    endtask

    task automatic test_ld();
        int ne;
        clear_prog();
        prog[0] = mk_raw(K_LD, 32'h0036_B103);
        prog[0].rw = 5'd2; prog[0].rb = 5'd13; prog[0].ra = 5'd0; prog[0].imm = 12'd3;
        run_program("ld_pos", 1'b0, ne);
    endtask

    task automatic test_neg_imm();
        int ne;
        clear_prog();
        prog[0] = mk_raw(K_LD, 32'hFF8A_B183);
        prog[0].rw = 5'd3; prog[0].rb = 5'd21; prog[0].ra = 5'd0; prog[0].imm = 12'hFF8;
        run_program("ld_neg", 1'b0, ne);
        n_tests++;
        if (dp_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            n_fail++;
            $display("FAIL ld_neg_imm: got %h, want FFFFFFFFFFFFFFF8", dp_imm);
        end
    endtask

    task automatic test_illegal();
        int ne;
        clear_prog();
        prog[0] = mk_ld(5'd7, 5'd1, 12'h010);
        prog[1] = mk_sd(5'd9, 5'd2, 12'h7FF);
        prog[2] = mk_raw(K_BAD, 32'h0000_0013);
        run_program("illegal", 1'b0, ne);
        n_tests++;
        if (ne !== 2 || pc !== 8'h08) begin
            n_fail++;
            $display("FAIL illegal_pulses: got %0d pulses pc=%h, want 2 pc=08", ne, pc);
        end
        // Restart from ERR goes back to address 0.
        run_program("illegal_restart", 1'b0, ne);
    endtask

    task automatic test_random();
        int ne;
        int len;
        logic [31:0] w;
        for (int p = 0; p < 10; p++) begin
            clear_prog();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 1)
                    prog[i] = mk_ld(5'($urandom), 5'($urandom), 12'($urandom));
                else
                    prog[i] = mk_sd(5'($urandom), 5'($urandom), 12'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                do begin
                    w = $urandom;
                    if ($urandom_range(0, 1) == 1) w[6:0] = w[5] ? 7'b0100011 : 7'b0000011;
                end while (is_supported(w));
                prog[len] = mk_raw(K_BAD, w);
            end
            run_program("random", p[0], ne);
            n_tests++;
            if (ne !== len) begin
                n_fail++;
                $display("FAIL random_pulses[%0d]: got %0d, want %0d", p, ne, len);
            end
        end
    endtask

    task automatic test_reset_exec();
        int ne;
        clear_prog();
        prog[0] = mk_ld(5'd1, 5'd2, 12'h004);
        prog[1] = mk_sd(5'd3, 5'd4, 12'h808);
        prog[2] = mk_ld(5'd5, 5'd6, 12'h00C);
        load_prog();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);   // now in EXEC of the 2nd instruction
        n_tests++;
        if (dp_enable !== 1'b1 || pc !== 8'h04) begin
            n_fail++;
            $display("FAIL rst_exec_pre: got en=%b pc=%h, want en=1 pc=04", dp_enable, pc);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({pc, dp_enable, dp_load_store, dp_a, dp_b, dp_w, dp_imm, busy, done, illegal} !== '0) begin
            n_fail++;
            $display("FAIL rst_exec_async: got pc=%h en=%b st=%b%b%b imm=%h, want all zero",
                     pc, dp_enable, busy, done, illegal, dp_imm);
        end
        @(negedge clk) rst = 1'b0;
        zero_model();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if ({dp_enable, busy, done, illegal} !== 4'b0000) begin
                n_fail++;
                $display("FAIL rst_exec_idle[%0d]: got en=%b st=%b%b%b, want idle",
                         i, dp_enable, busy, done, illegal);
            end
        end
        run_program("rst_exec_restart", 1'b0, ne);
    endtask

    task automatic test_wrap();
        logic [3:0] exp_pc;
        for (int i = 0; i < 4; i++) imem4[i] = enc_ld(5'(i + 10), 5'(i), 12'(i));
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        exp_pc = 4'h0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({busy4, dp_enable4, pc4} !== {2'b10, exp_pc}) begin
                n_fail++;
                $display("FAIL wrap_fetch[%0d]: got busy=%b en=%b pc=%h, want busy=1 en=0 pc=%h",
                         i, busy4, dp_enable4, pc4, exp_pc);
            end
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({busy4, dp_enable4, dp_load_store4, dp_w4, pc4} !==
                {3'b111, 5'((i % 4) + 10), exp_pc}) begin
                n_fail++;
                $display("FAIL wrap_exec[%0d]: got en=%b w=%0d pc=%h, want en=1 w=%0d pc=%h",
                         i, dp_enable4, dp_w4, pc4, (i % 4) + 10, exp_pc);
            end
            start4 = 1'b0;
            exp_pc = exp_pc + 4'd4;
            @(negedge clk);
        end
        start4 = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    initial begin
        clear_prog();
        load_prog();
        for (int i = 0; i < 4; i++) imem4[i] = 32'h0;
        zero_model();
        test_reset();
        test_sd_halt();
        test_ld();
        test_neg_imm();
        test_illegal();
        test_random();
        test_reset_exec();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
